mult3_accum: RTL
================

Name: mult3_accum

Overview:
- Sequential stage directly downstream of the 3x3 structural multiplier.
- Consumes its 6-bit product stream through a valid/ready handshake and accumulates a packet of products, delimited by in_last, into a saturating sum.
- Presents the finished sum, product count and overflow flag on a registered output handshake.
- Forms the multiply-accumulate datapath around the combinational multiplier.

Parameters:
- ACC_W, 10, accumulator and out_sum width; must be >= 6.
- CNT_W, 4, product-counter and out_cnt width; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- clr  input  1  synchronous abort; discards the partial packet and any pending output.
- in_valid  input  1  p_in is valid this cycle.
- in_ready  output  1  block can accept p_in.
- p_in  input  6  unsigned product, P[5:0], from the multiplier.
- in_last  input  1  marks the final product of the packet; qualified by in_valid.
- out_valid  output  1  out_sum, out_cnt and out_ovf are valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  saturated packet sum.
- out_cnt  output  CNT_W  number of products accepted, saturating.
- out_ovf  output  1  sticky flag; sum saturated at least once in the packet.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
  - in_ready=1 while reset is deasserted and state is not OUT.
- States:
  - IDLE: no product accepted yet.
  - ACC: at least one product accepted.
  - OUT: result held.
- in_ready is combinational: (state!=OUT). No bypass from out_ready to in_ready.
- Accept (in_valid & in_ready):
  - nsum = acc + zero-extended p_in.
  - If nsum > 2^ACC_W-1: acc = 2^ACC_W-1 and ovf is set. Otherwise acc = nsum.
  - cnt = min(cnt+1, 2^CNT_W-1).
- Transitions:
  - IDLE, accept without last -> ACC.
  - IDLE or ACC, accept with last -> OUT.
    - out_sum, out_cnt and out_ovf load the post-update values.
    - out_valid=1 on the next cycle. Latency from the last-product accept edge to out_valid high is 1 clock.
  - ACC, accept without last -> ACC.
  - OUT, out_valid & out_ready -> IDLE.
    - acc, cnt and ovf clear; out_valid=0 on the next cycle.
    - out_* data registers keep their last values.
- in_last with in_valid=0 is ignored.
- A single-product packet (last on the first beat) is legal and goes IDLE -> OUT.
- In OUT, out_sum, out_cnt and out_ovf are stable until the handshake, regardless of in_valid.
- Priority:
  - clr=1 (sync) overrides everything: acc, cnt and ovf cleared, out_valid=0, state=IDLE. A concurrent input beat is dropped.
  - out_* data registers are unchanged by clr.
- rst_n asserted mid-packet or in OUT: all state is lost immediately. No output is produced for the interrupted packet.
- p_in values 50..63 cannot be produced by the multiplier but are summed as given. No range check.
- Saturation is sticky within a packet. Once acc = max, further beats keep acc = max.

Decomposition:
- Package mult3_pkg holds:
  - PROD_W=6.
  - The state enum {IDLE, ACC, OUT} with 2-bit encoding 00/01/10.
  - A function sat_max(width) returning 2^width-1.
- One natural sub-module, mult3_sat_add: combinational ACC_W-bit + 6-bit saturating adder with an ovf output. It is reused by future MAC variants.
- The FSM, counter and output registers stay in mult3_accum.

Test Plan:
- Single beat: p_in=49 (7x7), in_last=1 -> next cycle out_valid=1, out_sum=49, out_cnt=1, out_ovf=0. in_ready=0 until out_ready.
- Packet of 4 beats, p_in=6,12,0,49 with last on the 4th -> out_sum=67, out_cnt=4, out_ovf=0. in_ready high throughout the packet.
- Saturation, ACC_W=10: 21 beats of 49, last on the 21st -> out_sum=1023, out_ovf=1, out_cnt=15 (saturated at CNT_W=4).
- Backpressure: hold out_ready=0 for 3 cycles in OUT while in_valid=1, p_in=5 -> outputs stable, in_ready=0, no beat accepted. Raise out_ready -> IDLE next cycle, then the next packet accumulates from 0.
- clr mid-packet after p_in=20,30, with clr asserted on the same cycle as a p_in=9 beat -> beat dropped. A following single beat p_in=4 with last gives out_sum=4, out_cnt=1.
- Async reset asserted mid-packet and in OUT with out_valid=1 -> out_valid falls without a clock edge. After release in_ready=1, and the first packet of 1+2 gives out_sum=3.

Source files
------------

// File: rtl/mult3_pkg.sv
// Shared types and constants for the 3x3 multiplier accumulate datapath.
package mult3_pkg;

   localparam int PROD_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      OUT  = 2'b10
   } state_t;

   function automatic logic [31:0] sat_max(input int unsigned width);
      if (width >= 32) begin
         return '1;
      end
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/mult3_sat_add.sv
// Combinational ACC_W-bit plus product-width saturating adder.
module mult3_sat_add
   import mult3_pkg::*;
#(
   parameter int ACC_W = 10
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] p,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] wide_sum;

   // One spare bit catches the carry out; a set carry means the sum clamps.
   assign wide_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
   assign ovf      = wide_sum[ACC_W];
   assign sum      = ovf ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];

endmodule

// File: rtl/mult3_accum.sv
// Accumulates a last-delimited packet of multiplier products into a saturating
// sum and presents sum, count and overflow on a registered output handshake.
module mult3_accum
   import mult3_pkg::*;
#(
   parameter int ACC_W = 10,
   parameter int CNT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] p_in,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;
   logic [CNT_W-1:0] cnt_inc;
   logic             ovf_upd;
   logic             accept;

   mult3_sat_add #(
      .ACC_W (ACC_W)
   ) u_sat_add (
      .acc (acc_q),
      .p   (p_in),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   assign in_ready = (state_q != OUT);
   assign accept   = in_valid & in_ready;
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign ovf_upd  = ovf_q | add_ovf;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;

      // clr drops any concurrent beat but leaves the last published result.
      if (clr) begin
         state_d     = IDLE;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, ACC: begin
               if (accept) begin
                  acc_d = add_sum;
                  cnt_d = cnt_inc;
                  ovf_d = ovf_upd;
                  if (in_last) begin
                     state_d     = OUT;
                     out_valid_d = 1'b1;
                     out_sum_d   = add_sum;
                     out_cnt_d   = cnt_inc;
                     out_ovf_d   = ovf_upd;
                  end else begin
                     state_d = ACC;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  state_d     = IDLE;
                  acc_d       = '0;
                  cnt_d       = '0;
                  ovf_d       = 1'b0;
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d     = IDLE;
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cnt   = out_cnt_q;
   assign out_ovf   = out_ovf_q;

endmodule
